// File: rtl/depuncturer_if.sv
// Signal bundle between the depuncturer, the upstream coded-bit source and
// the downstream Viterbi decoder. Clock and reset are kept as plain ports on
// the design itself.
interface depuncturer_if #(
  parameter int CNT_W = 10
);

  logic             Start;
  logic [1:0]       Rate;
  logic [CNT_W-1:0] Num_Pairs;
  logic             In_Data;
  logic             In_Valid;
  logic             In_Ready;
  logic             Out_A;
  logic             Out_B;
  logic             Out_EraseA;
  logic             Out_EraseB;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Done;

  // Environment side: starts frames, supplies coded bits, accepts pairs.
  modport master (
    output Start, Rate, Num_Pairs, In_Data, In_Valid, Out_Ready,
    input  In_Ready, Out_A, Out_B, Out_EraseA, Out_EraseB, Out_Valid, Done
  );

  // Depuncturer side.
  modport slave (
    input  Start, Rate, Num_Pairs, In_Data, In_Valid, Out_Ready,
    output In_Ready, Out_A, Out_B, Out_EraseA, Out_EraseB, Out_Valid, Done
  );

endinterface

// File: rtl/depuncturer.sv
// 802.11a-style depuncturer. Rebuilds the rate-1/2 (A,B) pair stream from a
// punctured hard-decision bit stream, inserting zero-valued placeholders with
// erase flags at the stolen positions. A frame is a fixed number of pairs
// announced with a single Start pulse; the puncturing pattern always starts
// at phase 0 of the period.
module depuncturer #(
  parameter int CNT_W = 10
) (
  input  logic         Clock,
  input  logic         Reset,
  depuncturer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_A = 2'd1,
    GET_B = 2'd2,
    EMIT  = 2'd3
  } state_e;

  // Internal rate code after normalisation: 0 = 1/2, 1 = 2/3, 2 = 3/4.
  localparam logic [1:0] RATE_1_2 = 2'd0;
  localparam logic [1:0] RATE_2_3 = 2'd1;
  localparam logic [1:0] RATE_3_4 = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] pairs_q, pairs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             outA_q, outA_d;
  logic             outB_q, outB_d;
  logic             eraseA_q, eraseA_d;
  logic             eraseB_q, eraseB_d;
  logic             done_q, done_d;

  logic [1:0]       period;
  logic [1:0]       phaseInc;
  logic [1:0]       phaseNext;
  logic             eraseAHere;
  logic             eraseBHere;
  logic             eraseANext;
  logic [CNT_W-1:0] cntInc;
  logic             lastPair;

  // Puncturing pattern decode for the current phase and the phase that follows it.
  always_comb begin
    period = 2'd1;
    case (rate_q)
      RATE_2_3: period = 2'd2;
      RATE_3_4: period = 2'd3;
      default:  period = 2'd1;
    endcase

    phaseInc  = phase_q + 2'd1;
    phaseNext = (phaseInc == period) ? 2'd0 : phaseInc;

    // Phase 1 steals B at 2/3 and 3/4; phase 2 steals A at 3/4.
    eraseBHere = (rate_q != RATE_1_2) && (phase_q == 2'd1);
    eraseAHere = (rate_q == RATE_3_4) && (phase_q == 2'd2);
    eraseANext = (rate_q == RATE_3_4) && (phaseNext == 2'd2);

    cntInc   = cnt_q + CNT_ONE;
    lastPair = (cntInc == pairs_q);
  end

  // Next-state and registered-output logic; registers hold unless a handshake fires.
  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    pairs_d  = pairs_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    outA_d   = outA_q;
    outB_d   = outB_q;
    eraseA_d = eraseA_q;
    eraseB_d = eraseB_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // In_Ready is low here, so a stale In_Valid alongside Start is never taken.
        if (bus.Start) begin
          rate_d  = (bus.Rate == 2'd3) ? RATE_1_2 : bus.Rate;
          pairs_d = (bus.Num_Pairs == '0) ? CNT_ONE : bus.Num_Pairs;
          cnt_d   = '0;
          phase_d = 2'd0;
          state_d = GET_A;
        end
      end

      GET_A: begin
        if (bus.In_Valid) begin
          outA_d   = bus.In_Data;
          eraseA_d = 1'b0;
          if (eraseBHere) begin
            outB_d   = 1'b0;
            eraseB_d = 1'b1;
            state_d  = EMIT;
          end else begin
            state_d  = GET_B;
          end
        end
      end

      GET_B: begin
        if (bus.In_Valid) begin
          outB_d   = bus.In_Data;
          eraseB_d = 1'b0;
          // Only reached without a GET_A when A is stolen in this phase.
          if (eraseAHere) begin
            outA_d   = 1'b0;
            eraseA_d = 1'b1;
          end
          state_d  = EMIT;
        end
      end

      EMIT: begin
        if (bus.Out_Ready) begin
          cnt_d   = cntInc;
          phase_d = phaseNext;
          if (lastPair) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (eraseANext) begin
            state_d = GET_B;
          end else begin
            state_d = GET_A;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      rate_q   <= 2'd0;
      pairs_q  <= '0;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      outA_q   <= 1'b0;
      outB_q   <= 1'b0;
      eraseA_q <= 1'b0;
      eraseB_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rate_q   <= rate_d;
      pairs_q  <= pairs_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      outA_q   <= outA_d;
      outB_q   <= outB_d;
      eraseA_q <= eraseA_d;
      eraseB_q <= eraseB_d;
      done_q   <= done_d;
    end
  end

  assign bus.In_Ready   = (state_q == GET_A) || (state_q == GET_B);
  assign bus.Out_Valid  = (state_q == EMIT);
  assign bus.Out_A      = outA_q;
  assign bus.Out_B      = outB_q;
  assign bus.Out_EraseA = eraseA_q;
  assign bus.Out_EraseB = eraseB_q;
  assign bus.Done       = done_q;

endmodule

// File: tb/tb_depuncturer.sv
// Self-checking bench for the depuncturer: directed vector table, hand-built
// reset/backpressure/mid-frame-Start sequences and randomized frames checked
// against a pattern-level reference model.
module tb_depuncturer;

  localparam int CNT_W  = 10;
  localparam int BUDGET = 600;
  localparam int NVEC   = 6;

  logic clk = 1'b0;
  logic rstN;

  depuncturer_if #(.CNT_W(CNT_W)) dif ();

  depuncturer #(.CNT_W(CNT_W)) dut (
    .Clock (clk),
    .Reset (rstN),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Coded bits offered to the DUT in order, and expected pairs {A,eA,B,eB}.
  logic       bitQ[$];
  logic [3:0] expQ[$];
  int         expBits;

  typedef struct packed {
    logic [1:0]      rate;
    logic [9:0]      npairs;
    logic [4:0]      nbits;
    logic [15:0]     bits;
    logic [3:0]      nexp;
    logic [7:0][3:0] exp;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic logic [3:0] pr(input logic a, input logic ea, input logic b, input logic eb);
    return {a, ea, b, eb};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference model: walk the puncturing period, stealing A in phase 2 of 3/4
  // and B in phase 1 of 2/3 and 3/4; stolen slots read as 0 with the flag set.
  function automatic void buildModel(input logic [1:0] rate, input int npairs);
    int period;
    int n;
    int b;
    int ph;
    bit stealA;
    bit stealB;
    logic va;
    logic vb;
    period = (rate == 2'b01) ? 2 : (rate == 2'b10) ? 3 : 1;
    n      = (npairs == 0) ? 1 : npairs;
    b      = 0;
    expQ.delete();
    for (int k = 0; k < n; k++) begin
      ph     = k % period;
      stealA = (period == 3) && (ph == 2);
      stealB = (ph == 1);
      va     = 1'b0;
      vb     = 1'b0;
      if (!stealA) begin va = bitQ[b]; b++; end
      if (!stealB) begin vb = bitQ[b]; b++; end
      expQ.push_back({va, stealA, vb, stealB});
    end
    expBits = b;
  endfunction

  function automatic void randomBits(input int n);
    bitQ.delete();
    for (int i = 0; i < n; i++) bitQ.push_back(1'($urandom));
  endfunction

  // Run one frame from IDLE. stopAfter > 0 abandons the frame right after that many pairs.
  task automatic applyStimulus(input logic [1:0] rate, input int npairs, input int validPct,
                               input int readyPct, input int stallCycles, input bit midStart,
                               input int stopAfter);
    int pairIdx;
    int bitIdx;
    int cyc;
    int stallLeft;
    bit holdPrev;
    bit finalHs;
    bit finished;
    bit stopNow;
    bit gap;
    bit rdy;
    bit vld;
    logic [3:0] held;
    logic [3:0] cur;
    pairIdx = 0; bitIdx = 0; cyc = 0; stallLeft = stallCycles;
    holdPrev = 0; finalHs = 0; finished = 0; stopNow = 0; gap = 0; held = '0;

    dif.Start     = 1'b1;
    dif.Rate      = rate;
    dif.Num_Pairs = npairs[CNT_W-1:0];
    dif.In_Valid  = 1'b1;
    dif.In_Data   = 1'($urandom);
    dif.Out_Ready = 1'($urandom);
    checkOutput("idleInReady", 32'(dif.In_Ready), 32'd0);
    @(posedge clk); #1;

    while (!finished && !stopNow && cyc < BUDGET) begin
      cyc++;
      dif.Rate      = 2'($urandom);
      dif.Num_Pairs = CNT_W'($urandom);
      dif.Start     = midStart && (cyc == 2);
      cur = {dif.Out_A, dif.Out_EraseA, dif.Out_B, dif.Out_EraseB};
      if (finalHs) begin
        checkOutput("done", 32'(dif.Done), 32'd1);
        checkOutput("idleAfterDone", 32'({dif.In_Ready, dif.Out_Valid}), 32'd0);
        finished = 1;
      end else begin
        checkOutput("noDone", 32'(dif.Done), 32'd0);
        if (!(dif.In_Ready || dif.Out_Valid)) gap = 1;
        if (dif.Out_Valid) begin
          checkOutput("inReadyInEmit", 32'(dif.In_Ready), 32'd0);
          if (holdPrev) checkOutput("stable", 32'(cur), 32'(held));
          if (stallLeft > 0) begin
            rdy = 0;
            stallLeft--;
          end else begin
            rdy = ($urandom_range(99) < readyPct);
          end
          dif.Out_Ready = rdy;
          if (rdy) begin
            if (pairIdx < expQ.size())
              checkOutput($sformatf("pair%0d", pairIdx), 32'(cur), 32'(expQ[pairIdx]));
            else
              failNow("extraPair", pairIdx + 1, expQ.size());
            pairIdx++;
            holdPrev = 0;
            if (pairIdx == expQ.size()) finalHs = 1;
            if (stopAfter > 0 && pairIdx == stopAfter) stopNow = 1;
          end else begin
            holdPrev = 1;
            held     = cur;
          end
        end else begin
          if (holdPrev) checkOutput("validHeld", 32'(dif.Out_Valid), 32'd1);
          holdPrev      = 0;
          dif.Out_Ready = 1'($urandom);
        end
        if (dif.In_Ready) begin
          vld          = ($urandom_range(99) < validPct);
          dif.In_Valid = vld;
          dif.In_Data  = (bitIdx < bitQ.size()) ? bitQ[bitIdx] : 1'($urandom);
          if (vld) bitIdx++;
        end else begin
          dif.In_Valid = 1'($urandom);
          dif.In_Data  = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    dif.Start = 1'b0;

    if (!stopNow) begin
      if (!finished) failNow("frameTimeout", pairIdx, expQ.size());
      checkOutput("bitsUsed", 32'(bitIdx), 32'(expBits));
      checkOutput("noGap", 32'(gap), 32'd0);
    end
  endtask

  // Directed vectors with hand-derived expected pairs; bits listed first-bit-at-MSB.
  task automatic loadTable();
    for (int i = 0; i < NVEC; i++) tbl[i] = '0;
    tbl[0].rate = 2'b00; tbl[0].npairs = 10'd3; tbl[0].nbits = 5'd6; tbl[0].bits = 16'b101101;
    tbl[0].nexp = 4'd3;
    tbl[0].exp[0] = pr(1,0,0,0); tbl[0].exp[1] = pr(1,0,1,0); tbl[0].exp[2] = pr(0,0,1,0);

    tbl[1].rate = 2'b10; tbl[1].npairs = 10'd6; tbl[1].nbits = 5'd8; tbl[1].bits = 16'b11011010;
    tbl[1].nexp = 4'd6;
    tbl[1].exp[0] = pr(1,0,1,0); tbl[1].exp[1] = pr(0,0,0,1); tbl[1].exp[2] = pr(0,1,1,0);
    tbl[1].exp[3] = pr(1,0,0,0); tbl[1].exp[4] = pr(1,0,0,1); tbl[1].exp[5] = pr(0,1,0,0);

    tbl[2].rate = 2'b01; tbl[2].npairs = 10'd4; tbl[2].nbits = 5'd6; tbl[2].bits = 16'b011100;
    tbl[2].nexp = 4'd4;
    tbl[2].exp[0] = pr(0,0,1,0); tbl[2].exp[1] = pr(1,0,0,1);
    tbl[2].exp[2] = pr(1,0,0,0); tbl[2].exp[3] = pr(0,0,0,1);

    tbl[3].rate = 2'b11; tbl[3].npairs = 10'd2; tbl[3].nbits = 5'd4; tbl[3].bits = 16'b1001;
    tbl[3].nexp = 4'd2;
    tbl[3].exp[0] = pr(1,0,0,0); tbl[3].exp[1] = pr(0,0,1,0);

    tbl[4].rate = 2'b00; tbl[4].npairs = 10'd0; tbl[4].nbits = 5'd2; tbl[4].bits = 16'b11;
    tbl[4].nexp = 4'd1;
    tbl[4].exp[0] = pr(1,0,1,0);

    tbl[5].rate = 2'b01; tbl[5].npairs = 10'd1; tbl[5].nbits = 5'd2; tbl[5].bits = 16'b10;
    tbl[5].nexp = 4'd1;
    tbl[5].exp[0] = pr(1,0,0,0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] rRate;
    int         rPairs;

    loadTable();

    // Reset dominates even with Start and data asserted.
    rstN          = 1'b0;
    dif.Start     = 1'b1;
    dif.Rate      = 2'b10;
    dif.Num_Pairs = 10'd5;
    dif.In_Data   = 1'b1;
    dif.In_Valid  = 1'b1;
    dif.Out_Ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOut", 32'({dif.In_Ready, dif.Out_Valid, dif.Out_A, dif.Out_B,
                                 dif.Out_EraseA, dif.Out_EraseB, dif.Done}), 32'd0);
    dif.Start    = 1'b0;
    dif.In_Valid = 1'b0;
    rstN         = 1'b1;
    @(posedge clk); #1;
    checkOutput("idleOut", 32'({dif.In_Ready, dif.Out_Valid, dif.Done}), 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < NVEC; i++) begin
      for (int pass = 0; pass < 2; pass++) begin
        bitQ.delete();
        for (int j = 0; j < int'(tbl[i].nbits); j++)
          bitQ.push_back(tbl[i].bits[int'(tbl[i].nbits) - 1 - j]);
        expQ.delete();
        for (int j = 0; j < int'(tbl[i].nexp); j++) expQ.push_back(tbl[i].exp[j]);
        expBits = int'(tbl[i].nbits);
        applyStimulus(tbl[i].rate, int'(tbl[i].npairs), (pass == 0) ? 100 : 60,
                      (pass == 0) ? 100 : 50, 0, 1'b0, 0);
      end
    end

    $display("[TB] backpressure: 5 stalled cycles on the first pair");
    randomBits(8);
    buildModel(2'b00, 3);
    applyStimulus(2'b00, 3, 100, 100, 5, 1'b0, 0);
    randomBits(10);
    buildModel(2'b10, 4);
    applyStimulus(2'b10, 4, 100, 100, 5, 1'b0, 0);

    $display("[TB] reset after two pairs of a 3/4 frame");
    randomBits(8);
    buildModel(2'b10, 3);
    applyStimulus(2'b10, 3, 100, 100, 0, 1'b0, 2);
    rstN          = 1'b0;
    dif.In_Valid  = 1'b1;
    dif.Out_Ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("resetMidFrame", 32'({dif.In_Ready, dif.Out_Valid, dif.Out_A, dif.Out_B,
                                      dif.Out_EraseA, dif.Out_EraseB, dif.Done}), 32'd0);
    rstN         = 1'b1;
    dif.In_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("noDoneAfterAbort", 32'(dif.Done), 32'd0);
    end
    randomBits(10);
    buildModel(2'b00, 4);
    applyStimulus(2'b00, 4, 100, 100, 0, 1'b0, 0);

    $display("[TB] mid-frame Start ignored, rate 11 frame");
    randomBits(12);
    buildModel(2'b11, 5);
    applyStimulus(2'b11, 5, 80, 80, 0, 1'b1, 0);

    $display("[TB] randomized frames against reference model");
    for (int f = 0; f < 15; f++) begin
      rRate  = 2'($urandom);
      rPairs = $urandom_range(12);
      randomBits(2 * rPairs + 4);
      buildModel(rRate, rPairs);
      applyStimulus(rRate, rPairs, $urandom_range(100, 50), $urandom_range(100, 40),
                    $urandom_range(3), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
